login_sequencer: RTL

Session controller that sequences the user-entry flow ahead of gameplay. After a start press it samples the guest/password selection switch, runs the password-entry phase with a bounded attempt count and per-attempt timeout, and imposes a timed lockout after repeated failures. It then enables the game datapath, TimerSpeed and UserLogin consumers, and holds that enable until the game reports completion.

---
 rtl/login_sequencer_if.sv | 30 +++
 rtl/login_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/login_sequencer_if.sv
// Bus between the login sequencer and the rest of the game.
// Handshake: every input is a one-cycle strobe or a level sampled on the rising
// clock edge. There is no back-pressure. Every output is a registered level
// that is valid for the whole cycle after the edge that changed it.
interface login_sequencer_if;
    logic       start;
    logic       user_sel;
    logic       tick;
    logic       pw_done;
    logic       pw_ok;
    logic       game_over;
    logic       pw_req;
    logic       guest;
    logic       game_en;
    logic       locked;
    logic [1:0] attempts_left;
    logic [2:0] dbg_state;

    // Environment side: drives the strobes and observes the session outputs.
    modport master (
        output start, user_sel, tick, pw_done, pw_ok, game_over,
        input  pw_req, guest, game_en, locked, attempts_left, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  start, user_sel, tick, pw_done, pw_ok, game_over,
        output pw_req, guest, game_en, locked, attempts_left, dbg_state
    );
endinterface

// File: rtl/login_sequencer.sv
// Session controller: start -> guest/password selection -> password attempts
// with per-attempt timeout -> timed lockout or gameplay until game_over.
module login_sequencer #(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned PW_TIMEOUT   = 15,
    parameter int unsigned LOCK_TICKS   = 10
) (
    input logic               clk,
    input logic               rst,
    login_sequencer_if.slave  bus
);

    localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);
    localparam logic [7:0] PW_TO   = 8'(PW_TIMEOUT);
    localparam logic [7:0] LOCK_T  = 8'(LOCK_TICKS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_PW_WAIT = 3'd2,
        S_PLAY    = 3'd3,
        S_LOCK    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       guest_q, guest_d;
    logic [1:0] att_q, att_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       fail;

    // Counter never exceeds the limit minus one, so the increment cannot wrap.
    assign cnt_inc = cnt_q + 8'd1;

    // State, guest flag, attempt count and tick counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            guest_q <= 1'b0;
            att_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            guest_q <= guest_d;
            att_q   <= att_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; pw_done takes priority over a coincident tick/timeout.
    always_comb begin
        state_d = state_q;
        guest_d = guest_q;
        att_d   = att_q;
        cnt_d   = cnt_q;
        fail    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (bus.user_sel) begin
                    state_d = S_PW_WAIT;
                    att_d   = MAX_ATT;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_PLAY;
                    guest_d = 1'b1;
                end
            end
            S_PW_WAIT: begin
                if (bus.pw_done) begin
                    cnt_d = 8'd0;
                    if (bus.pw_ok) begin
                        state_d = S_PLAY;
                        guest_d = 1'b0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (bus.tick) begin
                    if (cnt_inc == PW_TO) fail = 1'b1;
                    else                  cnt_d = cnt_inc;
                end
                if (fail) begin
                    cnt_d = 8'd0;
                    if (att_q == 2'd1) begin
                        state_d = S_LOCK;
                        att_d   = 2'd0;
                    end else begin
                        att_d = att_q - 2'd1;
                    end
                end
            end
            S_LOCK: begin
                if (bus.tick) begin
                    if (cnt_inc == LOCK_T) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_PLAY: begin
                if (bus.game_over) begin
                    state_d = S_IDLE;
                    guest_d = 1'b0;
                    att_d   = 2'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                guest_d = 1'b0;
                att_d   = 2'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Moore outputs decoded straight from the registered state.
    assign bus.pw_req        = (state_q == S_PW_WAIT);
    assign bus.game_en       = (state_q == S_PLAY);
    assign bus.locked        = (state_q == S_LOCK);
    assign bus.guest         = guest_q;
    assign bus.attempts_left = att_q;
    assign bus.dbg_state     = state_q;

endmodule
